riscv_writeback_stage: RTL and testbench
========================================

Name: riscv_writeback_stage

Overview:
- Parametrised successor to the pipelined writeback block: owns the MEM/WB pipeline register, load-data extraction and the result select.
- Drives the register-file write port and the W-stage forwarding source.
- Supports stall and flush, which the current combinational-only writeback does not.
- Sits between the memory stage and the register file / hazard unit.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- N_RES_SRC, 4, number of result sources; the result_src field is clog2(N_RES_SRC) bits, minimum 1.
- REG_ADDR_W, 5, register index width.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rstn  input  1  asynchronous, active-low reset.
- i_stall_w  input  1  hold the MEM/WB register.
- i_flush_w  input  1  load a bubble into MEM/WB.
- i_valid_m  input  1  M-stage instruction valid.
- i_alu_result_m  input  XLEN  ALU result; also the load address.
- i_read_data_m  input  XLEN  raw aligned data-memory word.
- i_pc_plus_4_m  input  XLEN  PC+4 for jal/jalr.
- i_imm_ext_m  input  XLEN  extended immediate for lui.
- i_result_src_m  input  clog2(N_RES_SRC)  result select.
- i_funct3_m  input  3  load size/sign.
- i_rd_m  input  REG_ADDR_W  destination register.
- i_reg_write_m  input  1  register-write enable.
- o_result_w  output  XLEN  writeback data.
- o_rd_w  output  REG_ADDR_W  writeback destination.
- o_reg_write_w  output  1  register-file write enable.
- o_valid_w  output  1  W-stage instruction valid.
- o_instret  output  64  retired count; present only with the optional feature.

Behaviour:
- Reset is asynchronous on i_rstn low. Every MEM/WB register clears to 0, so o_result_w=0, o_rd_w=0, o_reg_write_w=0, o_valid_w=0 (and o_instret=0). Reset asserted mid-operation discards the held instruction.
- Register update on each rising i_clk, in priority order:
  - i_flush_w: valid=0, reg_write=0, all other fields 0.
  - else i_stall_w: all fields hold.
  - else capture the M-stage inputs, including byte offset = i_alu_result_m[1:0] (bits [2:0] when XLEN=64).
- Flush has priority over stall when both are asserted.
- Latency is 1 cycle: M inputs at edge n appear on W outputs after edge n. The outputs are combinational from the registered fields.
- o_reg_write_w = reg_write & valid & (rd != 0). Writes to x0 are never issued.
- Result select on the registered src:
  - 0 = ALU result.
  - 1 = extracted load data.
  - 2 = PC+4.
  - 3 = immediate.
  - Codes >= N_RES_SRC select the ALU result.
- Load extraction, little-endian, from the registered word and offset:
  - funct3 000 lb: byte[offset], sign-extended.
  - 100 lbu: byte[offset], zero-extended.
  - 001 lh: halfword selected by offset[1] (XLEN=64 uses offset[2:1]), sign-extended.
  - 101 lhu: same halfword, zero-extended.
  - 010 lw: word, sign-extended to XLEN (XLEN=32: word as-is).
  - 110 lwu (XLEN=64 only): word, zero-extended.
  - 011 ld (XLEN=64 only): full doubleword.
  - Unlisted funct3: raw word passed through.
- Misaligned offsets: offset[0] is ignored for half/word accesses. Alignment faults are raised upstream; no fault is raised here.
- A bubble (valid=0) still drives o_result_w from the held fields. The consumer qualifies on o_reg_write_w.

Optional Feature:
- Macro: RISCV_WB_INSTRET_EN.
- Defined:
  - Adds a 64-bit o_instret counter.
  - Increments by 1 on every rising edge where valid=1 and i_stall_w=0 (instruction leaving W).
  - Wraps from 2^64-1 to 0.
  - Cleared by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package riscv_wb_pkg holds:
  - result-select encodings RES_ALU/RES_LOAD/RES_PC4/RES_IMM;
  - load funct3 constants F3_LB/LH/LW/LD/LBU/LHU/LWU.
- One sub-module, riscv_load_ext (combinational extractor: word, offset, funct3 -> XLEN data), instantiated once.
- The result select reuses the existing riscv_mux with N_MUX_IN=N_RES_SRC.

Test Plan:
- Reset: i_rstn=0 mid-stream with valid data held -> all outputs 0 immediately, without waiting for a clock edge; after release the first captured instruction appears after one edge.
- Loads: word 0x8070_F0A5 with offset 1 and funct3:
  - 000 -> 0xFFFF_FFF0
  - 100 -> 0x0000_00F0
  - offset 2, funct3 001 -> 0xFFFF_8070
  - offset 2, funct3 101 -> 0x0000_8070
- Result select: src 0 with ALU 0x1234 -> 0x1234; src 2 with PC+4 0x104 -> 0x104; src 3 with imm 0xABCD_E000 -> 0xABCD_E000.
- x0 suppression: reg_write=1, rd=0, valid=1 -> o_reg_write_w=0; the same with rd=5 -> 1, o_rd_w=5.
- Stall/flush:
  - stall for 3 cycles -> outputs frozen while new M inputs toggle;
  - stall+flush in the same cycle -> o_valid_w=0, o_reg_write_w=0 next cycle.
- With RISCV_WB_INSTRET_EN: 10 valid instructions, 2 stalled cycles, 1 flushed bubble -> o_instret=10; preload near 2^64-1 -> wraps to 0.

Source files
------------

// File: rtl/riscv_wb_pkg.sv
// Shared encodings for the RISC-V writeback stage.
// Result-select codes, load funct3 values and offset-width helper.
package riscv_wb_pkg;

    localparam int RES_ALU  = 0;
    localparam int RES_LOAD = 1;
    localparam int RES_PC4  = 2;
    localparam int RES_IMM  = 3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    function automatic int off_w(input int xlen);
        return (xlen == 64) ? 3 : 2;
    endfunction

endpackage

// File: rtl/riscv_load_ext.sv
// Little-endian load-data extractor (byte/half/word/double, signed or not).
// Ports: word (aligned memory word), offset (byte offset), funct3, data.
module riscv_load_ext
    import riscv_wb_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int OFF_W = (XLEN == 64) ? 3 : 2
) (
    input  logic [XLEN-1:0]  word,
    input  logic [OFF_W-1:0] offset,
    input  logic [2:0]       funct3,
    output logic [XLEN-1:0]  data
);

    logic [XLEN-1:0] b_sh;
    logic [XLEN-1:0] h_sh;
    logic [XLEN-1:0] lw_d;
    logic [XLEN-1:0] lwu_d;
    logic [7:0]      b;
    logic [15:0]     h;

    // offset[0] is dropped for halfwords, so misaligned halves round down
    assign b_sh = word >> {offset, 3'b000};
    assign h_sh = word >> {offset[OFF_W-1:1], 4'b0000};
    assign b    = b_sh[7:0];
    assign h    = h_sh[15:0];

    if (XLEN == 64) begin : g_rv64
        logic [XLEN-1:0] w_sh;
        logic [31:0]     w;
        assign w_sh  = word >> {offset[OFF_W-1], 5'b00000};
        assign w     = w_sh[31:0];
        assign lw_d  = {{32{w[31]}}, w};
        assign lwu_d = {32'b0, w};
    end else begin : g_rv32
        // lwu is not a valid RV32 load: falls through as the raw word
        assign lw_d  = word;
        assign lwu_d = word;
    end

    always_comb begin
        data = word;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){b[7]}}, b};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, b};
            F3_LH:   data = {{(XLEN-16){h[15]}}, h};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, h};
            F3_LW:   data = lw_d;
            F3_LWU:  data = lwu_d;
            F3_LD:   data = word;
            default: data = word;
        endcase
    end

endmodule

// File: rtl/riscv_mux.sv
// Generic N-input one-hot-free select mux.
// Ports: sel (index), data (packed inputs), out; out-of-range sel picks data[0].
module riscv_mux #(
    parameter  int N_MUX_IN = 4,
    parameter  int WIDTH    = 32,
    localparam int SEL_W    = (N_MUX_IN > 1) ? $clog2(N_MUX_IN) : 1
) (
    input  logic [SEL_W-1:0]               sel,
    input  logic [N_MUX_IN-1:0][WIDTH-1:0] data,
    output logic [WIDTH-1:0]               out
);

    always_comb begin
        out = data[0];
        for (int i = 0; i < N_MUX_IN; i++) begin
            if (sel == SEL_W'(i)) out = data[i];
        end
    end

endmodule

// File: rtl/riscv_writeback_stage.sv
// RISC-V W stage: MEM/WB register with stall/flush, load extraction, result mux.
// Ports: i_* M-stage inputs and stall/flush; o_* register-file write port and
// W forwarding source. Define RISCV_WB_INSTRET_EN to add the o_instret counter.
module riscv_writeback_stage
    import riscv_wb_pkg::*;
#(
    parameter  int XLEN       = 32,
    parameter  int N_RES_SRC  = 4,
    parameter  int REG_ADDR_W = 5,
    localparam int SRC_W      = (N_RES_SRC > 1) ? $clog2(N_RES_SRC) : 1,
    localparam int OFF_W      = (XLEN == 64) ? 3 : 2
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_stall_w,
    input  logic                  i_flush_w,
    input  logic                  i_valid_m,
    input  logic [XLEN-1:0]       i_alu_result_m,
    input  logic [XLEN-1:0]       i_read_data_m,
    input  logic [XLEN-1:0]       i_pc_plus_4_m,
    input  logic [XLEN-1:0]       i_imm_ext_m,
    input  logic [SRC_W-1:0]      i_result_src_m,
    input  logic [2:0]            i_funct3_m,
    input  logic [REG_ADDR_W-1:0] i_rd_m,
    input  logic                  i_reg_write_m,
    output logic [XLEN-1:0]       o_result_w,
    output logic [REG_ADDR_W-1:0] o_rd_w,
    output logic                  o_reg_write_w,
    output logic                  o_valid_w
`ifdef RISCV_WB_INSTRET_EN
    ,
    output logic [63:0]           o_instret
`endif
);

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       alu;
        logic [XLEN-1:0]       rdata;
        logic [XLEN-1:0]       pc4;
        logic [XLEN-1:0]       imm;
        logic [SRC_W-1:0]      src;
        logic [2:0]            funct3;
        logic [OFF_W-1:0]      offset;
    } mem_wb_t;

    mem_wb_t                        wb_q;
    mem_wb_t                        wb_d;
    logic [XLEN-1:0]                load_data;
    logic [N_RES_SRC-1:0][XLEN-1:0] res_in;

    always_comb begin
        wb_d.valid     = i_valid_m;
        wb_d.reg_write = i_reg_write_m;
        wb_d.rd        = i_rd_m;
        wb_d.alu       = i_alu_result_m;
        wb_d.rdata     = i_read_data_m;
        wb_d.pc4       = i_pc_plus_4_m;
        wb_d.imm       = i_imm_ext_m;
        wb_d.src       = i_result_src_m;
        wb_d.funct3    = i_funct3_m;
        wb_d.offset    = i_alu_result_m[OFF_W-1:0];
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wb_q <= '0;
        end else if (i_flush_w) begin
            wb_q <= '0;
        end else if (!i_stall_w) begin
            wb_q <= wb_d;
        end
    end

`ifdef RISCV_WB_INSTRET_EN
    logic [63:0] instret_q;

    // Retire = instruction leaving W, which a flush does not prevent
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            instret_q <= '0;
        end else if (wb_q.valid && !i_stall_w) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign o_instret = instret_q;
`endif

    riscv_load_ext #(
        .XLEN (XLEN)
    ) u_load_ext (
        .word   (wb_q.rdata),
        .offset (wb_q.offset),
        .funct3 (wb_q.funct3),
        .data   (load_data)
    );

    // Unassigned codes beyond the four known sources fall back to ALU
    for (genvar i = 0; i < N_RES_SRC; i++) begin : g_src
        assign res_in[i] = (i == RES_LOAD) ? load_data :
                           (i == RES_PC4)  ? wb_q.pc4  :
                           (i == RES_IMM)  ? wb_q.imm  :
                                             wb_q.alu;
    end

    riscv_mux #(
        .N_MUX_IN (N_RES_SRC),
        .WIDTH    (XLEN)
    ) u_res_mux (
        .sel  (wb_q.src),
        .data (res_in),
        .out  (o_result_w)
    );

    assign o_rd_w        = wb_q.rd;
    assign o_valid_w     = wb_q.valid;
    assign o_reg_write_w = wb_q.reg_write & wb_q.valid & (|wb_q.rd);

endmodule

// File: tb/tb_riscv_writeback_stage.sv
// Directed self-checking bench for riscv_writeback_stage (XLEN=32).
// Covers reset, load extraction, result select, x0, stall/flush, instret.
module tb_riscv_writeback_stage;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        valid_m = 1'b0;
    logic [31:0] alu_m = '0;
    logic [31:0] rdata_m = '0;
    logic [31:0] pc4_m = '0;
    logic [31:0] imm_m = '0;
    logic [1:0]  src_m = '0;
    logic [2:0]  f3_m = '0;
    logic [4:0]  rd_m = '0;
    logic        rw_m = 1'b0;
    logic [31:0] result_w;
    logic [4:0]  rd_w;
    logic        rw_w;
    logic        valid_w;
`ifdef RISCV_WB_INSTRET_EN
    logic [63:0] instret;
`endif

    int tests = 0;
    int fails = 0;

    riscv_writeback_stage dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .i_stall_w      (stall),
        .i_flush_w      (flush),
        .i_valid_m      (valid_m),
        .i_alu_result_m (alu_m),
        .i_read_data_m  (rdata_m),
        .i_pc_plus_4_m  (pc4_m),
        .i_imm_ext_m    (imm_m),
        .i_result_src_m (src_m),
        .i_funct3_m     (f3_m),
        .i_rd_m         (rd_m),
        .i_reg_write_m  (rw_m),
        .o_result_w     (result_w),
        .o_rd_w         (rd_w),
        .o_reg_write_w  (rw_w),
        .o_valid_w      (valid_w)
`ifdef RISCV_WB_INSTRET_EN
        ,
        .o_instret      (instret)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [31:0] pc4,
                         input logic [31:0] imm, input logic [1:0] src,
                         input logic [2:0] f3, input logic [4:0] rd,
                         input logic rw);
        valid_m = v;
        alu_m   = alu;
        rdata_m = rdata;
        pc4_m   = pc4;
        imm_m   = imm;
        src_m   = src;
        f3_m    = f3;
        rd_m    = rd;
        rw_m    = rw;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_res"}, 64'(result_w), 64'h0);
        check({tag, "_rd"}, 64'(rd_w), 64'h0);
        check({tag, "_rw"}, 64'(rw_w), 64'h0);
        check({tag, "_vld"}, 64'(valid_w), 64'h0);
    endtask

    initial begin
        #2;
        check_zero("rst0");
`ifdef RISCV_WB_INSTRET_EN
        check("rst0_ir", instret, 64'h0);
`endif
        #10;
        rstn = 1'b1;

        // Loads from 0x8070_F0A5
        drive(1, 32'h1001, 32'h8070_F0A5, 0, 0, 2'd1, 3'b000, 5'd5, 1);
        tick();
        check("lb_o1", 64'(result_w), 64'hFFFF_FFF0);
        check("lb_vld", 64'(valid_w), 64'h1);
        check("lb_rw", 64'(rw_w), 64'h1);
        check("lb_rd", 64'(rd_w), 64'd5);
        f3_m = 3'b100;
        tick();
        check("lbu_o1", 64'(result_w), 64'h0000_00F0);
        alu_m = 32'h1002;
        f3_m  = 3'b001;
        tick();
        check("lh_o2", 64'(result_w), 64'hFFFF_8070);
        f3_m = 3'b101;
        tick();
        check("lhu_o2", 64'(result_w), 64'h0000_8070);
        alu_m = 32'h1003;
        f3_m  = 3'b001;
        tick();
        check("lh_o3", 64'(result_w), 64'hFFFF_8070);
        alu_m = 32'h1000;
        tick();
        check("lh_o0", 64'(result_w), 64'hFFFF_F0A5);
        f3_m = 3'b010;
        tick();
        check("lw", 64'(result_w), 64'h8070_F0A5);
        f3_m = 3'b111;
        tick();
        check("f3_raw", 64'(result_w), 64'h8070_F0A5);

        // Result select
        drive(1, 32'h1234, 32'hDEAD_BEEF, 32'h104, 32'hABCD_E000,
              2'd0, 3'b010, 5'd6, 1);
        tick();
        check("src_alu", 64'(result_w), 64'h1234);
        src_m = 2'd2;
        tick();
        check("src_pc4", 64'(result_w), 64'h104);
        src_m = 2'd3;
        tick();
        check("src_imm", 64'(result_w), 64'hABCD_E000);

        // x0 suppression and bubble qualification
        drive(1, 32'h77, 0, 0, 0, 2'd0, 3'b010, 5'd0, 1);
        tick();
        check("x0_rw", 64'(rw_w), 64'h0);
        check("x0_vld", 64'(valid_w), 64'h1);
        rd_m = 5'd5;
        tick();
        check("x5_rw", 64'(rw_w), 64'h1);
        check("x5_rd", 64'(rd_w), 64'd5);
        valid_m = 1'b0;
        tick();
        check("bub_rw", 64'(rw_w), 64'h0);
        check("bub_res", 64'(result_w), 64'h77);

        // Stall holds for 3 cycles while M toggles
        drive(1, 32'h5555, 0, 0, 0, 2'd0, 3'b010, 5'd7, 1);
        tick();
        check("pre_stall", 64'(result_w), 64'h5555);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(i[0], 32'hA000 + 32'(i), 0, 32'h9, 32'h9,
                  2'(i), 3'b000, 5'(i + 10), 1);
            tick();
            check("stall_res", 64'(result_w), 64'h5555);
            check("stall_rd", 64'(rd_w), 64'd7);
            check("stall_vld", 64'(valid_w), 64'h1);
        end

        // Flush wins over stall
        flush = 1'b1;
        tick();
        check("flush_vld", 64'(valid_w), 64'h0);
        check("flush_rw", 64'(rw_w), 64'h0);
        check("flush_res", 64'(result_w), 64'h0);
        flush = 1'b0;
        stall = 1'b0;

        // Asynchronous reset mid-stream
        drive(1, 32'hCAFE, 0, 0, 0, 2'd0, 3'b010, 5'd9, 1);
        tick();
        check("pre_rst", 64'(result_w), 64'hCAFE);
        drive(1, 32'hBEEF, 0, 0, 0, 2'd0, 3'b010, 5'd3, 1);
        #2;
        rstn = 1'b0;
        #1;
        check_zero("arst");
        #2;
        rstn = 1'b1;
        #1;
        check("post_rst_hold", 64'(valid_w), 64'h0);
        tick();
        check("post_rst_res", 64'(result_w), 64'hBEEF);
        check("post_rst_rd", 64'(rd_w), 64'd3);

`ifdef RISCV_WB_INSTRET_EN
        rstn = 1'b0;
        #1;
        check("ir_rst", instret, 64'h0);
        rstn = 1'b1;
        drive(1, 32'h1, 0, 0, 0, 2'd0, 3'b010, 5'd1, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 4) begin
                stall = 1'b1;
                tick();
                tick();
                stall = 1'b0;
            end
        end
        valid_m = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        tick();
        check("ir_cnt", instret, 64'd10);
        valid_m = 1'b1;
        tick();
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        valid_m = 1'b0;
        tick();
        check("ir_wrap", instret, 64'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
